lmi_ifill: RTL and testbench
============================

LMI_IFILL -- requirements
Module: lmi_ifill

Interface
REQ-001 Parameter BEATS, default 4, SHALL set the beats per line fill; it is a power of two, 2..8.
REQ-002 Parameter TIMEOUT_CYC, default 255, SHALL set the bus inactivity limit in cycles; it is 8 bits wide.
REQ-003 CLK, in, 1: the single clock; every flop is rising-edge.
REQ-004 RESET_D1_R_N, in, 1: reset, asynchronous, active-low.
REQ-005 IW_MISS_P, in, 1: line-fill start pulse from the IRAM controller.
REQ-006 MISS_ADDR, in, 32: physical address of the missing instruction.
REQ-007 MEMZEROFIRST, in, 1: start the burst at beat 0 of the line.
REQ-008 FL_REQ, out, 1: bus burst-read request.
REQ-009 FL_ADDR, out, 32: burst start address.
REQ-010 BUS_GNT, in, 1: bus request accepted.
REQ-011 BUS_RVALID, in, 1: read beat valid.
REQ-012 BUS_RDATA, in, 32: read beat data.
REQ-013 BUS_RLAST, in, 1: last beat of the burst.
REQ-014 BUS_ERR, in, 1: beat error, qualified by BUS_RVALID.
REQ-015 IS_VAL, out, 1: beat valid to the IRAM fill port.
REQ-016 IS_DATA, out, 32: beat data to the IRAM fill port.
REQ-017 FL_BUSY, out, 1: fill in progress.
REQ-018 FL_ERR_R, out, 1: sticky fill-error flag.
REQ-019 ERR_CLR, in, 1: clears FL_ERR_R.

Function
REQ-020 The FSM SHALL be one-hot with states IDLE, REQ, DATA and FLUSH.
- Only IDLE accepts IW_MISS_P.
- IW_MISS_P in any other state SHALL be ignored.
REQ-021 IDLE with IW_MISS_P SHALL go to REQ next cycle and capture FL_ADDR in the same edge.
- FL_ADDR = MISS_ADDR[31:2] with bits [1:0]=0.
- When MEMZEROFIRST=1, the line-offset bits are also forced to 0.
REQ-022 FL_REQ SHALL equal state REQ.
- REQ with BUS_GNT SHALL go to DATA and clear the beat counter.
- FL_ADDR SHALL be held stable while in REQ.
REQ-023 In DATA, each BUS_RVALID cycle SHALL drive IS_VAL=1 and IS_DATA=BUS_RDATA, registered, 1 cycle later, and increment the beat counter.
- Counter width is log2(BEATS); it wraps at BEATS.
REQ-024 On the BEATS-th valid beat, DATA SHALL return to IDLE.
- BUS_RLAST on that beat is expected.
- BUS_RVALID seen in IDLE SHALL be ignored.
REQ-025 BUS_RLAST on an earlier beat, or BUS_ERR on any beat, SHALL set FL_ERR_R and move to FLUSH.
- The erroneous beat is forwarded with IS_DATA=0.
REQ-026 FLUSH SHALL assert IS_VAL with IS_DATA=0 once per cycle until the total forwarded beat count reaches BEATS, then return to IDLE.
- This guarantees the IRAM fill sequence always completes.
REQ-027 FL_BUSY SHALL be 1 in every state except IDLE.
REQ-028 IS_VAL SHALL never exceed BEATS pulses per accepted miss.
REQ-029 When ERR_CLR and an error-set condition occur in the same cycle, the set SHALL win.

Reset
REQ-030 Asserting RESET_D1_R_N SHALL immediately force:
- state IDLE;
- FL_REQ=0, FL_ADDR=0, IS_VAL=0, IS_DATA=0;
- FL_BUSY=0, FL_ERR_R=0;
- beat counter 0, timeout counter 0.
REQ-031 Reset asserted mid-fill SHALL abandon the fill with no further IS_VAL.
- Bus beats arriving after reset release SHALL be ignored.

Configuration
REQ-032 Macro LMI_IFILL_TIMEOUT_EN SHALL compile in an 8-bit inactivity counter.
- It counts cycles in REQ without BUS_GNT, or in DATA without BUS_RVALID, and clears on any such event.
- Reaching TIMEOUT_CYC SHALL set FL_ERR_R, deassert FL_REQ and enter FLUSH.
- Without the macro, no counter exists and REQ/DATA wait indefinitely.

Verification
REQ-033 Normal fill:
- Stimulus: miss at 0x0000_1008, MEMZEROFIRST=0, GNT after 2 cycles, 4 beats A0..A3.
- Response: FL_ADDR=0x0000_1008; IS_VAL x4 with data A0..A3, each 1 cycle after RVALID; FL_BUSY falls after the 4th; FL_ERR_R=0.
REQ-034 Zero-first:
- Stimulus: miss at 0x0000_100C, MEMZEROFIRST=1.
- Response: FL_ADDR=0x0000_1000.
REQ-035 Error beat:
- Stimulus: BUS_ERR on beat 2.
- Response: beat 2 forwarded as 0; beats 3-4 flushed as 0 in consecutive cycles; FL_ERR_R=1 until ERR_CLR.
REQ-036 Early RLAST:
- Stimulus: RLAST on beat 1.
- Response: 3 zero beats flushed; total IS_VAL=4; FL_ERR_R=1.
REQ-037 Reset mid-fill:
- Stimulus: RESET_D1_R_N low after beat 1.
- Response: all outputs 0 immediately; no IS_VAL after release.
REQ-038 With LMI_IFILL_TIMEOUT_EN:
- Stimulus: BUS_GNT withheld.
- Response: after 255 cycles FL_REQ=0, 4 zero beats, FL_ERR_R=1.

Source files
------------

// File: rtl/lmi_ifill.sv
// rtl/lmi_ifill.sv - instruction line-fill engine between the IRAM controller and the bus
//
// Purpose:
//   On a miss pulse from the IRAM controller, issues one burst-read request
//   and forwards BEATS read beats, registered, to the IRAM fill port. If the
//   bus ends the burst early or flags an error, the remaining beats are
//   flushed as zeros so that the IRAM always sees a complete line of BEATS
//   beats. A sticky error flag records such fills until software clears it.
//
// Optional feature:
//   LMI_IFILL_TIMEOUT_EN - adds an 8-bit bus inactivity counter. A fill that
//   waits TIMEOUT_CYC cycles for a grant or for a beat is aborted into FLUSH
//   and flagged as an error. Without the macro the engine waits indefinitely.
//
// Parameters:
//   BEATS        beats per line fill (power of two, 2..8)
//   TIMEOUT_CYC  inactivity limit in cycles (only used with the macro)
//
// Ports:
//   CLK           in   rising-edge clock
//   RESET_D1_R_N  in   asynchronous active-low reset
//   IW_MISS_P     in   line-fill start pulse (accepted only when idle)
//   MISS_ADDR     in   [31:0] physical address of the missing instruction
//   MEMZEROFIRST  in   start the burst at beat 0 of the line
//   FL_REQ        out  burst-read request
//   FL_ADDR       out  [31:0] burst start address
//   BUS_GNT       in   request accepted
//   BUS_RVALID    in   read beat valid
//   BUS_RDATA     in   [31:0] read beat data
//   BUS_RLAST     in   last beat of the burst
//   BUS_ERR       in   beat error, qualified by BUS_RVALID
//   IS_VAL        out  beat valid to the IRAM fill port
//   IS_DATA       out  [31:0] beat data to the IRAM fill port
//   FL_BUSY       out  fill in progress
//   FL_ERR_R      out  sticky fill-error flag
//   ERR_CLR       in   clears FL_ERR_R (a simultaneous set wins)

module lmi_ifill #(
  parameter int         BEATS       = 4,
  parameter logic [7:0] TIMEOUT_CYC = 8'd255
) (
  input  logic        CLK,
  input  logic        RESET_D1_R_N,
  input  logic        IW_MISS_P,
  input  logic [31:0] MISS_ADDR,
  input  logic        MEMZEROFIRST,
  output logic        FL_REQ,
  output logic [31:0] FL_ADDR,
  input  logic        BUS_GNT,
  input  logic        BUS_RVALID,
  input  logic [31:0] BUS_RDATA,
  input  logic        BUS_RLAST,
  input  logic        BUS_ERR,
  output logic        IS_VAL,
  output logic [31:0] IS_DATA,
  output logic        FL_BUSY,
  output logic        FL_ERR_R,
  input  logic        ERR_CLR
);

  localparam int CW    = $clog2(BEATS);
  localparam int OFF_W = CW + 2;
  // Clears the byte offset within the line (word offset plus byte lane).
  localparam logic [31:0] LINE_MASK = ~((32'd1 << OFF_W) - 32'd1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  if (BEATS < 2 || BEATS > 8 || (BEATS & (BEATS - 1)) != 0 || TIMEOUT_CYC == 8'd0)
  begin : g_param_chk
    $error("lmi_ifill: BEATS must be a power of two in 2..8 and TIMEOUT_CYC nonzero");
  end

  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_REQ   = 4'b0010,
    S_DATA  = 4'b0100,
    S_FLUSH = 4'b1000
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          is_val_q, is_val_d;
  logic [31:0]   is_data_q, is_data_d;
  logic          err_q, err_d;
  logic          err_set;
  logic          to_hit;

`ifdef LMI_IFILL_TIMEOUT_EN
  logic [7:0] to_cnt_q, to_cnt_d;

  // Counts consecutive cycles spent waiting on the bus; any grant or beat
  // restarts it, and it stays at zero outside REQ/DATA.
  always_comb begin
    to_cnt_d = 8'd0;
    to_hit   = 1'b0;
    if ((state_q == S_REQ && !BUS_GNT) || (state_q == S_DATA && !BUS_RVALID)) begin
      if (to_cnt_q == TIMEOUT_CYC - 8'd1) begin
        to_hit = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_D1_R_N) begin
    if (!RESET_D1_R_N) begin
      to_cnt_q <= 8'd0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    is_val_d  = 1'b0;
    is_data_d = 32'd0;
    err_set   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (IW_MISS_P) begin
          addr_d = MISS_ADDR & ~32'd3;
          if (MEMZEROFIRST) begin
            addr_d = addr_d & LINE_MASK;
          end
          cnt_d   = '0;
          state_d = S_REQ;
        end
      end

      S_REQ: begin
        if (BUS_GNT) begin
          cnt_d   = '0;
          state_d = S_DATA;
        end else if (to_hit) begin
          err_set = 1'b1;
          state_d = S_FLUSH;
        end
      end

      S_DATA: begin
        if (BUS_RVALID) begin
          is_val_d = 1'b1;
          cnt_d    = cnt_q + CW'(1);
          if (BUS_ERR || (BUS_RLAST && cnt_q != LAST_BEAT)) begin
            // Bad beat is forwarded as zero; if it was the final beat the
            // line is already complete and there is nothing left to flush.
            err_set = 1'b1;
            state_d = (cnt_q == LAST_BEAT) ? S_IDLE : S_FLUSH;
          end else begin
            is_data_d = BUS_RDATA;
            if (cnt_q == LAST_BEAT) begin
              state_d = S_IDLE;
            end
          end
        end else if (to_hit) begin
          err_set = 1'b1;
          state_d = S_FLUSH;
        end
      end

      S_FLUSH: begin
        // Pad the line with zero beats; the beat counter already holds the
        // number of beats forwarded for this miss.
        is_val_d = 1'b1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST_BEAT) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    err_d = err_q;
    if (ERR_CLR) begin
      err_d = 1'b0;
    end
    if (err_set) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_D1_R_N) begin
    if (!RESET_D1_R_N) begin
      state_q   <= S_IDLE;
      addr_q    <= 32'd0;
      cnt_q     <= '0;
      is_val_q  <= 1'b0;
      is_data_q <= 32'd0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      is_val_q  <= is_val_d;
      is_data_q <= is_data_d;
      err_q     <= err_d;
    end
  end

  assign FL_REQ   = (state_q == S_REQ);
  assign FL_ADDR  = addr_q;
  assign IS_VAL   = is_val_q;
  assign IS_DATA  = is_data_q;
  assign FL_BUSY  = (state_q != S_IDLE);
  assign FL_ERR_R = err_q;

endmodule

// File: tb/tb_lmi_ifill.sv
// tb/tb_lmi_ifill.sv - directed table-driven testbench for lmi_ifill

module tb_lmi_ifill;

  logic        CLK = 1'b0;
  logic        RESET_D1_R_N;
  logic        IW_MISS_P;
  logic [31:0] MISS_ADDR;
  logic        MEMZEROFIRST;
  logic        FL_REQ;
  logic [31:0] FL_ADDR;
  logic        BUS_GNT;
  logic        BUS_RVALID;
  logic [31:0] BUS_RDATA;
  logic        BUS_RLAST;
  logic        BUS_ERR;
  logic        IS_VAL;
  logic [31:0] IS_DATA;
  logic        FL_BUSY;
  logic        FL_ERR_R;
  logic        ERR_CLR;

  int checks   = 0;
  int failures = 0;

  lmi_ifill dut (
    .CLK          (CLK),
    .RESET_D1_R_N (RESET_D1_R_N),
    .IW_MISS_P    (IW_MISS_P),
    .MISS_ADDR    (MISS_ADDR),
    .MEMZEROFIRST (MEMZEROFIRST),
    .FL_REQ       (FL_REQ),
    .FL_ADDR      (FL_ADDR),
    .BUS_GNT      (BUS_GNT),
    .BUS_RVALID   (BUS_RVALID),
    .BUS_RDATA    (BUS_RDATA),
    .BUS_RLAST    (BUS_RLAST),
    .BUS_ERR      (BUS_ERR),
    .IS_VAL       (IS_VAL),
    .IS_DATA      (IS_DATA),
    .FL_BUSY      (FL_BUSY),
    .FL_ERR_R     (FL_ERR_R),
    .ERR_CLR      (ERR_CLR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        miss;
    logic [31:0] addr;
    logic        mzf;
    logic        gnt;
    logic        rv;
    logic [31:0] rd;
    logic        rl;
    logic        er;
    logic        clr;
    logic        x_req;
    logic [31:0] x_addr;
    logic        x_val;
    logic [31:0] x_data;
    logic        x_busy;
    logic        x_err;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic miss, logic [31:0] addr, logic mzf, logic gnt,
                              logic rv, logic [31:0] rd, logic rl, logic er, logic clr,
                              logic x_req, logic [31:0] x_addr, logic x_val,
                              logic [31:0] x_data, logic x_busy, logic x_err);
    vec_t v;
    v.miss = miss; v.addr = addr; v.mzf = mzf; v.gnt = gnt;
    v.rv = rv; v.rd = rd; v.rl = rl; v.er = er; v.clr = clr;
    v.x_req = x_req; v.x_addr = x_addr; v.x_val = x_val;
    v.x_data = x_data; v.x_busy = x_busy; v.x_err = x_err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    IW_MISS_P = 1'b0; MISS_ADDR = 32'd0; MEMZEROFIRST = 1'b0;
    BUS_GNT = 1'b0; BUS_RVALID = 1'b0; BUS_RDATA = 32'd0;
    BUS_RLAST = 1'b0; BUS_ERR = 1'b0; ERR_CLR = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"},  {31'd0, FL_REQ},   32'd0);
    chk({tag, "_addr"}, FL_ADDR,           32'd0);
    chk({tag, "_val"},  {31'd0, IS_VAL},   32'd0);
    chk({tag, "_data"}, IS_DATA,           32'd0);
    chk({tag, "_busy"}, {31'd0, FL_BUSY},  32'd0);
    chk({tag, "_err"},  {31'd0, FL_ERR_R}, 32'd0);
  endtask

  initial begin
    int n;
    int v;
    int bad;

    // Normal fill: miss at 0x1008, grant after 2 cycles, beats A0..A3
    vt.push_back(mk(1, 32'h1008, 0, 0, 0, 0, 0, 0, 0,  1, 32'h1008, 0, 0, 1, 0));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,         1, 32'h1008, 0, 0, 1, 0));
    vt.push_back(mk(0, 0, 0, 0, 1, 32'hBAD, 0, 0, 0,   1, 32'h1008, 0, 0, 1, 0));
    vt.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0,         0, 32'h1008, 0, 0, 1, 0));
    vt.push_back(mk(0, 0, 0, 0, 1, 32'hA5A50000, 0, 0, 0, 0, 32'h1008, 1, 32'hA5A50000, 1, 0));
    vt.push_back(mk(1, 32'h2000, 0, 0, 1, 32'hA5A50001, 0, 0, 0, 0, 32'h1008, 1, 32'hA5A50001, 1, 0));
    vt.push_back(mk(0, 0, 0, 0, 1, 32'hA5A50002, 0, 0, 0, 0, 32'h1008, 1, 32'hA5A50002, 1, 0));
    vt.push_back(mk(0, 0, 0, 0, 1, 32'hA5A50003, 1, 0, 0, 0, 32'h1008, 1, 32'hA5A50003, 0, 0));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,         0, 32'h1008, 0, 0, 0, 0));
    // Zero-first miss at 0x100C, then BUS_ERR on beat 2
    vt.push_back(mk(1, 32'h100C, 1, 0, 0, 0, 0, 0, 0,  1, 32'h1000, 0, 0, 1, 0));
    vt.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0,         0, 32'h1000, 0, 0, 1, 0));
    vt.push_back(mk(0, 0, 0, 0, 1, 32'h12345678, 0, 0, 0, 0, 32'h1000, 1, 32'h12345678, 1, 0));
    vt.push_back(mk(0, 0, 0, 0, 1, 32'hFFFFFFFF, 0, 1, 0, 0, 32'h1000, 1, 0, 1, 1));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,         0, 32'h1000, 1, 0, 1, 1));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,         0, 32'h1000, 1, 0, 0, 1));
    vt.push_back(mk(0, 0, 0, 0, 1, 32'hDEAD, 0, 0, 0,  0, 32'h1000, 0, 0, 0, 1));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,         0, 32'h1000, 0, 0, 0, 1));
    // Early RLAST on beat 1, with ERR_CLR colliding with the set
    vt.push_back(mk(1, 32'h3004, 0, 0, 0, 0, 0, 0, 0,  1, 32'h3004, 0, 0, 1, 1));
    vt.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0,         0, 32'h3004, 0, 0, 1, 1));
    vt.push_back(mk(0, 0, 0, 0, 1, 32'hCAFE, 1, 0, 1,  0, 32'h3004, 1, 0, 1, 1));
    vt.push_back(mk(0, 0, 0, 0, 1, 32'h5555, 0, 0, 0,  0, 32'h3004, 1, 0, 1, 1));
    vt.push_back(mk(1, 32'h4000, 0, 0, 0, 0, 0, 0, 0,  0, 32'h3004, 1, 0, 1, 1));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,         0, 32'h3004, 1, 0, 0, 1));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1,         0, 32'h3004, 0, 0, 0, 0));

    idle_inputs();
    RESET_D1_R_N = 1'b0;
    #12;
    chk_all_zero("reset");
    @(posedge CLK); #1;
    RESET_D1_R_N = 1'b1;

    for (int i = 0; i < vt.size(); i++) begin
      IW_MISS_P = vt[i].miss; MISS_ADDR = vt[i].addr; MEMZEROFIRST = vt[i].mzf;
      BUS_GNT = vt[i].gnt; BUS_RVALID = vt[i].rv; BUS_RDATA = vt[i].rd;
      BUS_RLAST = vt[i].rl; BUS_ERR = vt[i].er; ERR_CLR = vt[i].clr;
      @(posedge CLK); #1;
      chk($sformatf("v%0d_req", i),  {31'd0, FL_REQ},   {31'd0, vt[i].x_req});
      chk($sformatf("v%0d_addr", i), FL_ADDR,           vt[i].x_addr);
      chk($sformatf("v%0d_val", i),  {31'd0, IS_VAL},   {31'd0, vt[i].x_val});
      chk($sformatf("v%0d_data", i), IS_DATA,           vt[i].x_data);
      chk($sformatf("v%0d_busy", i), {31'd0, FL_BUSY},  {31'd0, vt[i].x_busy});
      chk($sformatf("v%0d_err", i),  {31'd0, FL_ERR_R}, {31'd0, vt[i].x_err});
    end
    idle_inputs();

    // Reset mid-fill: asynchronous clear, then stray beats after release
    IW_MISS_P = 1'b1; MISS_ADDR = 32'h5000;
    @(posedge CLK); #1;
    IW_MISS_P = 1'b0; BUS_GNT = 1'b1;
    @(posedge CLK); #1;
    BUS_GNT = 1'b0; BUS_RVALID = 1'b1; BUS_RDATA = 32'h77;
    @(posedge CLK); #1;
    chk("rst_pre_val", {31'd0, IS_VAL}, 32'd1);
    chk("rst_pre_data", IS_DATA, 32'h77);
    BUS_RDATA = 32'h88;
    #2;
    RESET_D1_R_N = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    @(posedge CLK); #1;
    RESET_D1_R_N = 1'b1;
    v = 0; bad = 0;
    for (int i = 0; i < 6; i++) begin
      BUS_RVALID = 1'b1; BUS_RDATA = 32'h99 + i; BUS_RLAST = (i == 3);
      @(posedge CLK); #1;
      if (IS_VAL) v++;
      if (FL_BUSY) bad++;
    end
    idle_inputs();
    chk("rst_after_vals", v, 0);
    chk("rst_after_busy", bad, 0);

    // Grant withheld
    IW_MISS_P = 1'b1; MISS_ADDR = 32'h6000;
    @(posedge CLK); #1;
    IW_MISS_P = 1'b0;
    n = 0;
    while (FL_REQ && n < 400) begin
      n++;
      @(posedge CLK); #1;
    end
`ifdef LMI_IFILL_TIMEOUT_EN
    chk("to_req_cycles", n, 255);
    v = 0; bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (IS_VAL) begin
        v++;
        if (IS_DATA !== 32'd0) bad++;
      end
      @(posedge CLK); #1;
    end
    chk("to_flush_vals", v, 4);
    chk("to_flush_zero", bad, 0);
    chk("to_err", {31'd0, FL_ERR_R}, 32'd1);
    chk("to_busy", {31'd0, FL_BUSY}, 32'd0);
`else
    chk("no_to_req_held", n, 400);
    chk("no_to_err", {31'd0, FL_ERR_R}, 32'd0);
    BUS_GNT = 1'b1;
    @(posedge CLK); #1;
    BUS_GNT = 1'b0;
    v = 0;
    for (int i = 0; i < 4; i++) begin
      BUS_RVALID = 1'b1; BUS_RDATA = 32'h600 + i; BUS_RLAST = (i == 3);
      @(posedge CLK); #1;
      if (IS_VAL && IS_DATA === 32'h600 + i) v++;
    end
    idle_inputs();
    @(posedge CLK); #1;
    chk("late_gnt_vals", v, 4);
    chk("late_gnt_busy", {31'd0, FL_BUSY}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
